ila_trigger_ctrl: RTL and testbench
===================================

# ila_trigger_ctrl

Trigger and capture-window controller for the ILA. It consumes probe vectors already brought into the capture clock domain by the synchronizer stage. It evaluates a per-bit mask/value/edge trigger condition and produces a qualified sample stream for the capture buffer: continuous pre-trigger samples, a one-cycle trigger marker, and exactly N post-trigger samples. It then stops and reports done.

## Interface
- WIDTH, 8: probe width in bits.
- POST_W, 16: width of the post-trigger sample count.
- OCC_W, 8: width of the occurrence count (used only with the occurrence feature).

- clk  in  1  capture clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- probe  in  WIDTH  synchronized probe vector.
- arm  in  1  single-cycle start pulse; accepted in IDLE or DONE.
- abort  in  1  returns to IDLE from any state; has priority over arm.
- cfg_mask  in  WIDTH  1 = bit participates in the trigger.
- cfg_value  in  WIDTH  level to match, or edge direction (1 = rising, 0 = falling).
- cfg_edge  in  WIDTH  1 = edge compare, 0 = level compare.
- cfg_post  in  POST_W  number of samples after the trigger sample.
- cfg_occur  in  OCC_W  trigger on match number cfg_occur+1.
- cap_valid  out  1  cap_data is a sample to store.
- cap_data  out  WIDTH  sample.
- cap_trig  out  1  marks the trigger sample; coincident with cap_valid.
- armed  out  1  state is ARMED.
- done  out  1  state is DONE.

## Operation
- Input pipeline (every cycle, all states):
  - d_q <= probe.
  - p_q <= d_q.
- Per-bit match:
  - bit_hit[i] = !cfg_mask[i] | (cfg_edge[i] ? (d_q[i]==cfg_value[i] && p_q[i]!=cfg_value[i]) : d_q[i]==cfg_value[i]).
  - hit = &bit_hit.
- Configuration:
  - cfg_* is latched into shadow registers when arm is accepted.
  - Later changes to cfg_* have no effect until the next arm.
- States and transitions:
  - IDLE: no output activity. arm -> ARMED.
  - ARMED: cap_valid=1 every cycle with cap_data=d_q. A qualifying hit sets cap_trig=1 for that sample, then goes to POST, or to DONE if shadow post==0. Edge comparisons are suppressed on the first ARMED cycle, where p_q is pre-arm history. Level-only conditions may fire on the first ARMED cycle.
  - POST: cap_valid=1, cap_trig=0. A counter loads shadow post at trigger and decrements once per sample. The state moves to DONE after exactly cfg_post samples. Further hits are ignored.
  - DONE: no output activity, done=1. arm -> ARMED with a fresh configuration latch.
- abort forces IDLE from any state on the next edge; the post and occurrence counters clear. If abort and arm are high in the same cycle, abort wins.
- arm while ARMED or POST is ignored.
- All-zero cfg_mask means hit=1, so the trigger fires on the first ARMED sample (the immediate-trigger case).
- The post counter is POST_W wide and never wraps. Maximum window is 2^POST_W−1 post samples.

## Timing
- probe to cap_data latency: 2 cycles (through d_q, then registered outputs).
- cap_valid, cap_data, cap_trig, armed and done are all registered outputs.
- First cap_valid appears the cycle after the state enters ARMED, which is 2 edges after the arm pulse is sampled.
- cap_trig is high for exactly 1 cycle per arm sequence.
- Total valid samples after cap_trig, excluding the trigger sample itself, equal cfg_post.
- done rises on the cycle after the last post sample.
- Reset values: state=IDLE; all outputs 0; d_q, p_q, counters and shadow registers 0.

## Configuration
- TRIG_OCCURRENCE_EN defined:
  - An OCC_W occurrence counter counts qualifying hits in ARMED.
  - Trigger fires on hit number cfg_occur+1; earlier hits are ordinary pre-trigger samples.
  - The counter clears on arm and abort.
- TRIG_OCCURRENCE_EN undefined:
  - cfg_occur port remains but is ignored.
  - The first hit triggers; no counter is built.

## Test plan
- Level trigger: mask=0x01, value=0x01, edge=0, post=4; probe bit0 rises 10 cycles after arm. Required: cap_trig on the sample with bit0=1; exactly 4 more cap_valid; done=1 the next cycle.
- Edge trigger: edge=0x02, value=0x00, mask=0x02; probe bit1 held 1 through arm, falls once. Required: no trigger on the first ARMED cycle; cap_trig on the falling sample only.
- post=0, mask=0: required cap_trig on the first valid sample and DONE on the next cycle, with cap_valid high for a single cycle.
- abort during POST with 3 of 8 post samples emitted: required cap_valid=0 from the next cycle and state IDLE. A subsequent arm must produce a full 8-sample window.
- Async reset asserted mid-POST, between clock edges: required outputs 0 immediately; state IDLE after release.
- TRIG_OCCURRENCE_EN, cfg_occur=2, three level pulses on bit0: required cap_trig on the third pulse only; undefined build triggers on the first.

Source files
------------

// File: rtl/ila_trigger_ctrl_if.sv
// ila_trigger_ctrl_if: probe, control, configuration and capture-stream
// signals of the ILA trigger controller, bundled as one interface.
// The master side drives probes/arm/abort/config and receives the capture
// stream; the slave side is the trigger controller itself.
interface ila_trigger_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int POST_W = 16,
  parameter int OCC_W  = 8
);
  logic [WIDTH-1:0]  probe;
  logic              arm;
  logic              abort;
  logic [WIDTH-1:0]  cfg_mask;
  logic [WIDTH-1:0]  cfg_value;
  logic [WIDTH-1:0]  cfg_edge;
  logic [POST_W-1:0] cfg_post;
  logic [OCC_W-1:0]  cfg_occur;
  logic              cap_valid;
  logic [WIDTH-1:0]  cap_data;
  logic              cap_trig;
  logic              armed;
  logic              done;

  modport master (
    output probe, arm, abort, cfg_mask, cfg_value, cfg_edge, cfg_post, cfg_occur,
    input  cap_valid, cap_data, cap_trig, armed, done
  );

  modport slave (
    input  probe, arm, abort, cfg_mask, cfg_value, cfg_edge, cfg_post, cfg_occur,
    output cap_valid, cap_data, cap_trig, armed, done
  );
endinterface

// File: rtl/ila_trigger_ctrl.sv
// ila_trigger_ctrl: ILA trigger and capture-window controller.
// Streams pre-trigger samples while armed, marks the trigger sample, emits
// exactly cfg_post further samples, then parks in DONE until re-armed.
// Optional feature macro: TRIG_OCCURRENCE_EN (trigger on hit number
// cfg_occur+1 instead of the first hit).
module ila_trigger_ctrl #(
  parameter int WIDTH  = 8,
  parameter int POST_W = 16,
  parameter int OCC_W  = 8
) (
  input logic clk,
  input logic rst,
  ila_trigger_ctrl_if.slave io_bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_dq;
  logic [WIDTH-1:0]  r_pq;
  logic [WIDTH-1:0]  r_shMask;
  logic [WIDTH-1:0]  r_shValue;
  logic [WIDTH-1:0]  r_shEdge;
  logic [POST_W-1:0] r_shPost;
  logic [POST_W-1:0] r_postCnt;
  logic              r_firstCycle;
  logic              r_capValid;
  logic [WIDTH-1:0]  r_capData;
  logic              r_capTrig;
  logic              r_armed;
  logic              r_done;

  logic [WIDTH-1:0]  w_bitHit;
  logic              w_hit;
  logic              w_trig;
  logic              w_armAccept;

  // Probe history: d_q is the current sample, p_q the one before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dq <= '0;
      r_pq <= '0;
    end else begin
      r_dq <= io_bus.probe;
      r_pq <= r_dq;
    end
  end

  // Per-bit trigger match against the shadow configuration; edge bits never
  // match on the first armed cycle because p_q still holds pre-arm history.
  always_comb begin
    w_bitHit = '1;
    for (int i = 0; i < WIDTH; i++) begin
      if (!r_shMask[i]) begin
        w_bitHit[i] = 1'b1;
      end else if (r_shEdge[i]) begin
        w_bitHit[i] = !r_firstCycle && (r_dq[i] == r_shValue[i]) && (r_pq[i] != r_shValue[i]);
      end else begin
        w_bitHit[i] = (r_dq[i] == r_shValue[i]);
      end
    end
  end

  assign w_hit       = &w_bitHit;
  assign w_armAccept = io_bus.arm && !io_bus.abort &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE));

`ifdef TRIG_OCCURRENCE_EN
  logic [OCC_W-1:0] r_shOccur;
  logic [OCC_W-1:0] r_occCnt;

  // Only hit number cfg_occur+1 qualifies as the trigger.
  assign w_trig = w_hit && (r_occCnt == r_shOccur);

  // Counts non-triggering hits while armed; restarts on every arm and abort.
  // It stops at the trigger hit, so it can never exceed cfg_occur or wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shOccur <= '0;
      r_occCnt  <= '0;
    end else if (io_bus.abort) begin
      r_occCnt <= '0;
    end else if (w_armAccept) begin
      r_shOccur <= io_bus.cfg_occur;
      r_occCnt  <= '0;
    end else if ((r_state == ST_ARMED) && w_hit && !w_trig) begin
      r_occCnt <= r_occCnt + 1'b1;
    end
  end
`else
  // Without occurrence counting the first hit is the trigger.
  assign w_trig = w_hit;
`endif

  // Main state machine with registered capture outputs; every output reflects
  // the state during the cycle just ended, so done follows the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shMask     <= '0;
      r_shValue    <= '0;
      r_shEdge     <= '0;
      r_shPost     <= '0;
      r_postCnt    <= '0;
      r_firstCycle <= 1'b0;
      r_capValid   <= 1'b0;
      r_capData    <= '0;
      r_capTrig    <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
    end else if (io_bus.abort) begin
      r_state      <= ST_IDLE;
      r_postCnt    <= '0;
      r_firstCycle <= 1'b0;
      r_capValid   <= 1'b0;
      r_capData    <= '0;
      r_capTrig    <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_firstCycle <= 1'b0;
      r_capValid   <= 1'b0;
      r_capData    <= '0;
      r_capTrig    <= 1'b0;
      r_armed      <= (r_state == ST_ARMED);
      r_done       <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (io_bus.arm) begin
            r_state      <= ST_ARMED;
            r_shMask     <= io_bus.cfg_mask;
            r_shValue    <= io_bus.cfg_value;
            r_shEdge     <= io_bus.cfg_edge;
            r_shPost     <= io_bus.cfg_post;
            r_firstCycle <= 1'b1;
          end
        end
        ST_ARMED: begin
          r_capValid <= 1'b1;
          r_capData  <= r_dq;
          r_capTrig  <= w_trig;
          if (w_trig) begin
            if (r_shPost == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state   <= ST_POST;
              r_postCnt <= r_shPost;
            end
          end
        end
        ST_POST: begin
          r_capValid <= 1'b1;
          r_capData  <= r_dq;
          r_postCnt  <= r_postCnt - 1'b1;
          if (r_postCnt == POST_W'(1)) begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.cap_valid = r_capValid;
  assign io_bus.cap_data  = r_capData;
  assign io_bus.cap_trig  = r_capTrig;
  assign io_bus.armed     = r_armed;
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_ila_trigger_ctrl.sv
// tb_ila_trigger_ctrl: directed self-checking bench for ila_trigger_ctrl.
// Observed outputs are packed as {cap_valid, cap_trig, armed, done, cap_data}
// and compared a short time after each rising edge.
module tb_ila_trigger_ctrl;

  localparam int WIDTH  = 8;
  localparam int POST_W = 16;
  localparam int OCC_W  = 8;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  ila_trigger_ctrl_if #(.WIDTH(WIDTH), .POST_W(POST_W), .OCC_W(OCC_W)) bus ();

  ila_trigger_ctrl #(.WIDTH(WIDTH), .POST_W(POST_W), .OCC_W(OCC_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Free-running 10 ns capture clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH+3:0] pk(input logic v, input logic t, input logic a,
                                          input logic d, input logic [WIDTH-1:0] data);
    return {v, t, a, d, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] probe, input logic arm, input logic abort);
    bus.probe = probe;
    bus.arm   = arm;
    bus.abort = abort;
  endtask

  task automatic setConfig(input logic [WIDTH-1:0] mask, input logic [WIDTH-1:0] value,
                           input logic [WIDTH-1:0] edgeSel, input logic [POST_W-1:0] post,
                           input logic [OCC_W-1:0] occur);
    bus.cfg_mask  = mask;
    bus.cfg_value = value;
    bus.cfg_edge  = edgeSel;
    bus.cfg_post  = post;
    bus.cfg_occur = occur;
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH+3:0] expected);
    logic [WIDTH+3:0] observed;
    observed = {bus.cap_valid, bus.cap_trig, bus.armed, bus.done, bus.cap_data};
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    setConfig(8'h00, 8'h00, 8'h00, 16'd0, 8'd0);
    #3;
    checkOutput("reset_state", pk(0, 0, 0, 0, 8'h00));
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("idle_after_reset", pk(0, 0, 0, 0, 8'h00));

    // Level trigger on bit0, four post samples.
    $display("[TB] level trigger");
    setConfig(8'h01, 8'h01, 8'h00, 16'd4, 8'd0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    step();
    checkOutput("lvl_arm_edge", pk(0, 0, 0, 0, 8'h00));
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkOutput("lvl_first_valid", pk(1, 0, 1, 0, 8'h00));
    setConfig(8'h00, 8'h00, 8'h00, 16'd0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      step();
      checkOutput("lvl_pretrig_shadowed", pk(1, 0, 1, 0, 8'h00));
    end
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    checkOutput("lvl_latency", pk(1, 0, 1, 0, 8'h00));
    step();
    checkOutput("lvl_trig", pk(1, 1, 1, 0, 8'h01));
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("lvl_post", pk(1, 0, 0, 0, 8'h01));
    end
    step();
    checkOutput("lvl_done", pk(0, 0, 0, 1, 8'h00));
    step();
    checkOutput("lvl_done_hold", pk(0, 0, 0, 1, 8'h00));

    // Falling-edge trigger on bit1; a fake edge on the first armed cycle is ignored.
    $display("[TB] edge trigger");
    applyStimulus(8'h02, 1'b0, 1'b0);
    step();
    step();
    setConfig(8'h02, 8'h00, 8'h02, 16'd2, 8'd0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    step();
    checkOutput("edge_arm_from_done", pk(0, 0, 0, 1, 8'h00));
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkOutput("edge_first_suppressed", pk(1, 0, 1, 0, 8'h00));
    applyStimulus(8'h02, 1'b0, 1'b0);
    step();
    step();
    checkOutput("edge_rising_ignored", pk(1, 0, 1, 0, 8'h02));
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkOutput("edge_before_fall", pk(1, 0, 1, 0, 8'h02));
    step();
    checkOutput("edge_trig", pk(1, 1, 1, 0, 8'h00));
    step();
    checkOutput("edge_post1", pk(1, 0, 0, 0, 8'h00));
    step();
    checkOutput("edge_post2", pk(1, 0, 0, 0, 8'h00));
    step();
    checkOutput("edge_done", pk(0, 0, 0, 1, 8'h00));

    // Immediate trigger with no post samples.
    $display("[TB] immediate trigger post=0");
    setConfig(8'h00, 8'h00, 8'h00, 16'd0, 8'd0);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    step();
    applyStimulus(8'h5A, 1'b0, 1'b0);
    step();
    checkOutput("imm_trig", pk(1, 1, 1, 0, 8'h5A));
    step();
    checkOutput("imm_done", pk(0, 0, 0, 1, 8'h00));

    // Abort after three of eight post samples, then abort-over-arm priority.
    $display("[TB] abort during post");
    setConfig(8'h00, 8'h00, 8'h00, 16'd8, 8'd0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    step();
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("abt_trig", pk(1, 1, 1, 0, 8'h33));
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("abt_post", pk(1, 0, 0, 0, 8'h33));
    end
    applyStimulus(8'h33, 1'b0, 1'b1);
    step();
    checkOutput("abt_cleared", pk(0, 0, 0, 0, 8'h00));
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("abt_idle", pk(0, 0, 0, 0, 8'h00));
    applyStimulus(8'h33, 1'b1, 1'b1);
    step();
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("abt_wins_over_arm", pk(0, 0, 0, 0, 8'h00));
    applyStimulus(8'h33, 1'b1, 1'b0);
    step();
    checkOutput("rearm_edge", pk(0, 0, 0, 0, 8'h00));
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("rearm_trig", pk(1, 1, 1, 0, 8'h33));
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'h33, (k == 1), 1'b0);
      step();
      checkOutput("rearm_post_full", pk(1, 0, 0, 0, 8'h33));
    end
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("rearm_done", pk(0, 0, 0, 1, 8'h00));

    // Asynchronous reset between edges in the middle of a post window.
    $display("[TB] async reset mid-post");
    applyStimulus(8'h33, 1'b1, 1'b0);
    step();
    applyStimulus(8'h33, 1'b0, 1'b0);
    step();
    checkOutput("rst_trig", pk(1, 1, 1, 0, 8'h33));
    step();
    checkOutput("rst_post", pk(1, 0, 0, 0, 8'h33));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_immediate", pk(0, 0, 0, 0, 8'h00));
    rst = 1'b0;
    step();
    checkOutput("rst_idle1", pk(0, 0, 0, 0, 8'h00));
    step();
    checkOutput("rst_idle2", pk(0, 0, 0, 0, 8'h00));

    // Three level pulses on bit0 with cfg_occur=2.
    $display("[TB] occurrence trigger");
    setConfig(8'h01, 8'h01, 8'h00, 16'd1, 8'd2);
    applyStimulus(8'h00, 1'b1, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
    checkOutput("occ_first_valid", pk(1, 0, 1, 0, 8'h00));
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
`ifdef TRIG_OCCURRENCE_EN
    checkOutput("occ_pulse1", pk(1, 0, 1, 0, 8'h01));
`else
    checkOutput("occ_pulse1", pk(1, 1, 1, 0, 8'h01));
`endif
    step();
`ifdef TRIG_OCCURRENCE_EN
    checkOutput("occ_after1", pk(1, 0, 1, 0, 8'h00));
`else
    checkOutput("occ_after1", pk(1, 0, 0, 0, 8'h00));
`endif
    step();
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
`ifdef TRIG_OCCURRENCE_EN
    checkOutput("occ_pulse2", pk(1, 0, 1, 0, 8'h01));
`else
    checkOutput("occ_pulse2", pk(0, 0, 0, 1, 8'h00));
`endif
    step();
    step();
    applyStimulus(8'h01, 1'b0, 1'b0);
    step();
    applyStimulus(8'h00, 1'b0, 1'b0);
    step();
`ifdef TRIG_OCCURRENCE_EN
    checkOutput("occ_pulse3", pk(1, 1, 1, 0, 8'h01));
`else
    checkOutput("occ_pulse3", pk(0, 0, 0, 1, 8'h00));
`endif
    step();
`ifdef TRIG_OCCURRENCE_EN
    checkOutput("occ_post", pk(1, 0, 0, 0, 8'h00));
`else
    checkOutput("occ_post", pk(0, 0, 0, 1, 8'h00));
`endif
    step();
    checkOutput("occ_done", pk(0, 0, 0, 1, 8'h00));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
